// File: rtl/fsmc_wb_pkg.sv
// Shared types and constants for the FSMC to Wishbone bridge.
// State encoding, byte-lane selects and the abort read pattern.
package fsmc_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ABORT
  } state_e;

  localparam logic [3:0]  SEL_LO    = 4'b0011;
  localparam logic [3:0]  SEL_HI    = 4'b1100;
  localparam logic [15:0] ABORT_PAT = 16'hDEAD;

endpackage

// File: rtl/fsmc_sync.sv
// N-bit multi-stage synchronizer bank for asynchronous active-low strobes.
// All flops reset to 1 so strobes read as deasserted.
module fsmc_sync #(
  parameter int N      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] stg_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stg_q[i] <= '1;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/fsmc_wb_bridge.sv
// FSMC async SRAM-style slave to Wishbone classic master bridge.
// Optional ack timeout/abort enabled by defining FSMC_WB_TIMEOUT_EN.
module fsmc_wb_bridge
  import fsmc_wb_pkg::*;
#(
  parameter int                 FSMC_AW        = 16,
  parameter int                 WB_AW          = 32,
  parameter logic [WB_AW-1:0]   ADR_BASE       = '0,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FSMC_AW-1:0] fsmc_adr,
  input  logic [15:0]        fsmc_dat_i,
  output logic [15:0]        fsmc_dat_o,
  output logic               fsmc_dat_oe,
  input  logic               fsmc_ce_n,
  input  logic               fsmc_we_n,
  input  logic               fsmc_oe_n,
  input  logic               fsmc_ub_n,
  input  logic               fsmc_lb_n,
  output logic               fsmc_nwait,
  output logic [WB_AW-1:0]   wb_adr_o,
  output logic [31:0]        wb_dat_o,
  input  logic [31:0]        wb_dat_i,
  output logic [3:0]         wb_sel_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  input  logic               wb_ack_i,
  output logic               err_o,
  input  logic               err_clr_i
);

  logic ce_s, we_s, oe_s, ub_s, lb_s;

  fsmc_sync #(
    .N      (5),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n}),
    .q_o   ({ce_s, we_s, oe_s, ub_s, lb_s})
  );

  state_e            state_q;
  logic              cyc_q, we_q, rd_q, hi_q;
  logic [3:0]        sel_q;
  logic [WB_AW-1:0]  adr_q;
  logic [31:0]       wdat_q;
  logic [15:0]       rdat_q;

  logic start_d, hi_d;
  // exactly one of we/oe, at least one lane
  assign start_d = !ce_s && (we_s ^ oe_s) && !(ub_s && lb_s);
  assign hi_d    = !ub_s && lb_s;

`ifdef FSMC_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  logic          err_q;
  assign tmo_hit = (state_q == S_REQ) && !wb_ack_i &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      hi_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
`ifdef FSMC_WB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q <= S_REQ;
            cyc_q   <= 1'b1;
            we_q    <= !we_s;
            rd_q    <= we_s;
            hi_q    <= hi_d;
            sel_q   <= hi_d ? SEL_HI : SEL_LO;
            adr_q   <= ADR_BASE + WB_AW'(fsmc_adr);
            if (!we_s) wdat_q <= hi_d ? {fsmc_dat_i, 16'h0} : {16'h0, fsmc_dat_i};
            else       wdat_q <= '0;
`ifdef FSMC_WB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (wb_ack_i) begin
            state_q <= S_DONE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            if (rd_q) rdat_q <= hi_q ? wb_dat_i[31:16] : wb_dat_i[15:0];
`ifdef FSMC_WB_TIMEOUT_EN
          end else if (tmo_hit) begin
            state_q <= S_ABORT;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            if (rd_q) rdat_q <= ABORT_PAT;
          end else begin
            tmo_q   <= tmo_q + 1'b1;
`endif
          end
        end
        S_DONE, S_ABORT: begin
          if (ce_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FSMC_WB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (err_clr_i) err_q <= 1'b0;
    else if (tmo_hit)   err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o = 1'b0;
`endif

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = wdat_q;
  assign fsmc_dat_o  = rdat_q;
  assign fsmc_nwait  = (state_q != S_REQ);
  assign fsmc_dat_oe = ((state_q == S_DONE) || (state_q == S_ABORT)) &&
                       rd_q && !oe_s;

endmodule

// File: doc/fsmc_wb_bridge.md
FSMC_WB_BRIDGE -- requirements
Module: fsmc_wb_bridge

Interface
REQ-001 SHALL have parameter FSMC_AW, default 16: width of the FSMC address bus.
REQ-002 SHALL have parameter WB_AW, default 32: width of the Wishbone address bus; SHALL be >= FSMC_AW.
REQ-003 SHALL have parameter ADR_BASE, default 0: WB_AW-bit constant added to the zero-extended FSMC address.
REQ-004 SHALL have parameter SYNC_STAGES, default 2 (min 2): flop count of the FSMC strobe synchronizers.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255: clocks to wait for wb_ack_i before aborting.
REQ-006 Ports: clk  in  1  system clock; one clock domain; reset is asynchronous and active-low.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 fsmc_adr in FSMC_AW; fsmc_dat_i in 16; fsmc_dat_o out 16; fsmc_dat_oe out 1 (top-level tristate enable).
REQ-009 fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n  in  1 each  FSMC strobes (asynchronous to clk).
REQ-010 fsmc_nwait  out  1  low = bridge busy, host SHALL extend its access.
REQ-011 wb_adr_o out WB_AW; wb_dat_o out 32; wb_dat_i in 32; wb_sel_o out 4; wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_ack_i in 1.
REQ-012 err_o  out  1  sticky timeout flag; err_clr_i  in  1  clears err_o.

Function
REQ-013 All five strobes SHALL pass through SYNC_STAGES-deep synchronizers; address and data SHALL be sampled only at transaction start.
REQ-014 States: IDLE, REQ, DONE, ABORT.
REQ-015 IDLE->REQ when synced ce_n=0, exactly one of we_n/oe_n=0, and at least one of ub_n/lb_n=0; other combinations SHALL start no cycle.
REQ-016 wb_cyc_o/wb_stb_o SHALL rise SYNC_STAGES+1 clocks after fsmc_ce_n falls; wb_adr_o = ADR_BASE + zero-extended fsmc_adr, modulo 2^WB_AW.
REQ-017 Lane: lb_n=0 -> wb_sel_o 4'b0011, low half; ub_n=0, lb_n=1 -> 4'b1100, high half; both low -> low half.
REQ-018 Write: wb_we_o=1; wb_dat_o carries fsmc_dat_i in the selected half and zeros in the other.
REQ-019 REQ->DONE on the clock wb_ack_i=1; cyc/stb SHALL drop on the next edge; wb_ack_i outside REQ SHALL be ignored.
REQ-020 Read: on ack, the selected half of wb_dat_i SHALL be registered into fsmc_dat_o.
REQ-021 fsmc_dat_oe=1 only in DONE/ABORT of a read while synced oe_n=0.
REQ-022 fsmc_nwait=0 in REQ; 1 in all other states.
REQ-023 DONE/ABORT->IDLE only after synced ce_n=1; one WB cycle per chip-select assertion.
REQ-024 Strobes released during REQ SHALL NOT abort the WB cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, cyc/stb/we=0, sel=0, adr/dat outputs=0, fsmc_dat_o=0, fsmc_dat_oe=0, fsmc_nwait=1, err_o=0, synchronizers=1, mid-cycle included.

Configuration
REQ-026 With FSMC_WB_TIMEOUT_EN defined: a counter runs in REQ; after TIMEOUT_CYCLES clocks without ack -> ABORT, cyc/stb drop, err_o=1, read data 16'hDEAD.
REQ-027 err_clr_i has priority over a new timeout in the same clock.
REQ-028 Without FSMC_WB_TIMEOUT_EN: no counter, REQ waits indefinitely, err_o tied 0, err_clr_i ignored.

Structure
REQ-029 Package fsmc_wb_pkg SHALL hold the state encoding, lane select constants and the 16'hDEAD abort pattern.
REQ-030 Sub-module fsmc_sync (parameterised N-bit, SYNC_STAGES-deep synchronizer bank, reset to 1) SHALL be instantiated once for the five strobes.

Verification
REQ-031 Write lb_n=0, adr 16'hAAAA, dat 16'h5555 -> wb_adr_o 32'h0000AAAA, wb_dat_o 32'h00005555, sel 4'b0011, we=1.
REQ-032 Write ub_n=0, adr 16'h5555, dat 16'hAAAA -> wb_dat_o 32'hAAAA0000, sel 4'b1100; ack held 3 clocks -> exactly one cycle.
REQ-033 wb_dat_i 32'hFEDCBA98: read lb_n=0 -> fsmc_dat_o 16'hBA98; read ub_n=0 -> 16'hFEDC; nwait low until ack.
REQ-034 ADR_BASE 32'hFFFF0000, adr 16'hFFFF -> wb_adr_o 32'hFFFFFFFF; adr 16'h0001 -> 32'hFFFF0001.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES 8, no ack -> cyc drops after 8 clocks, err_o=1, read returns 16'hDEAD; err_clr_i -> err_o=0.
REQ-036 rst_n low mid-REQ -> cyc/stb 0 and nwait 1 without a clock edge; we_n=oe_n=0 -> no WB cycle.
